// File: rtl/bcd_clock_pkg.sv
// Shared definitions for the BCD clock: seven-segment digit patterns, BCD
// limit constants, BCD helpers and the load-handshake state enum.
package bcd_clock_pkg;

    // BCD limits
    localparam logic [7:0] BcdMax59 = 8'h59;
    localparam logic [7:0] BcdMax23 = 8'h23;
    localparam logic [7:0] BcdMax12 = 8'h12;

    // Seven-segment patterns, abcdefg with a in the MSB
    localparam logic [6:0] Seg0   = 7'b1111110;
    localparam logic [6:0] Seg1   = 7'b0110000;
    localparam logic [6:0] Seg2   = 7'b1101101;
    localparam logic [6:0] Seg3   = 7'b1111001;
    localparam logic [6:0] Seg4   = 7'b0110011;
    localparam logic [6:0] Seg5   = 7'b1011011;
    localparam logic [6:0] Seg6   = 7'b1011111;
    localparam logic [6:0] Seg7   = 7'b1110000;
    localparam logic [6:0] Seg8   = 7'b1111111;
    localparam logic [6:0] Seg9   = 7'b1111011;
    localparam logic [6:0] SegOff = 7'b0000000;

    typedef enum logic [0:0] {
        StReady,
        StAck
    } load_st_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = Seg0;
            4'd1:    s = Seg1;
            4'd2:    s = Seg2;
            4'd3:    s = Seg3;
            4'd4:    s = Seg4;
            4'd5:    s = Seg5;
            4'd6:    s = Seg6;
            4'd7:    s = Seg7;
            4'd8:    s = Seg8;
            4'd9:    s = Seg9;
            default: s = SegOff;
        endcase
        return s;
    endfunction

    // True when both nibbles are decimal digits and the value does not exceed max
    function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Two-digit BCD increment without wrap handling
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter wrapping at {MAX_TENS, MAX_UNITS} -> 00.
// Ports:
//   clk_i      counting clock
//   reset_i    synchronous active-high reset to 00
//   inc_i      advance by one this edge
//   load_i     load load_val_i this edge (takes priority over inc_i)
//   load_val_i value to load
//   val_o      registered value
//   nxt_o      value that will be registered on the next edge (ignoring reset)
//   carry_o    inc_i while at the maximum, i.e. this edge wraps
module bcd_digit_pair #(
    parameter logic [3:0] MAX_TENS  = 4'd5,
    parameter logic [3:0] MAX_UNITS = 4'd9
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] val_o,
    output logic [7:0] nxt_o,
    output logic       carry_o
);
    import bcd_clock_pkg::*;

    logic [7:0] val_q, val_d;
    logic       at_max;

    assign at_max  = (val_q == {MAX_TENS, MAX_UNITS});
    assign carry_o = inc_i && at_max;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i) begin
            val_d = at_max ? 8'h00 : bcd_inc(val_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            val_q <= 8'h00;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;
    assign nxt_o = val_d;

endmodule

// File: rtl/bcd_clock_param.sv
// BCD HH:MM:SS timekeeper with 12/24-hour mode, validated load handshake,
// rollover strobes and a six-digit seven-segment decode.
// Optional alarm comparator enabled by defining BCD_CLOCK_ALARM_EN; without it
// the alarm inputs are ignored and alarm_out is 0.
// Ports:
//   clk_1hz, reset        counting clock, synchronous active-high reset
//   run                   advance one second per edge when 1
//   set_valid/set_ready   load handshake; set_hh/mm/ss/pm are the load values
//   set_error             one-cycle pulse for a rejected load
//   hh/mm/ss_bcd, pm      registered time
//   tick_min/hour/day     one-cycle rollover strobes
//   seg_out               {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u} x abcdefg
//   alarm_*               alarm compare time, arm, ack and sticky flag
module bcd_clock_param #(
    parameter bit HOUR_MODE_12    = 1'b0,
    parameter bit SEG_ACTIVE_LOW  = 1'b0,
    parameter bit BLANK_LEAD_HOUR = 1'b0
) (
    input  logic        clk_1hz,
    input  logic        reset,
    input  logic        run,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [7:0]  set_hh,
    input  logic [7:0]  set_mm,
    input  logic [7:0]  set_ss,
    input  logic        set_pm,
    output logic        set_error,
    output logic [7:0]  hh_bcd,
    output logic [7:0]  mm_bcd,
    output logic [7:0]  ss_bcd,
    output logic        pm,
    output logic        tick_min,
    output logic        tick_hour,
    output logic        tick_day,
    output logic [41:0] seg_out,
    input  logic [7:0]  alarm_hh,
    input  logic [7:0]  alarm_mm,
    input  logic        alarm_pm,
    input  logic        alarm_arm,
    input  logic        alarm_ack,
    output logic        alarm_out
);
    import bcd_clock_pkg::*;

    localparam logic [7:0] HhReset = HOUR_MODE_12 ? BcdMax12 : 8'h00;

    load_st_e   state_q, state_d;
    logic [7:0] hh_q, hh_d;
    logic       pm_q, pm_d;
    logic       tick_min_q, tick_hour_q, tick_day_q;
    logic       set_error_q;
    logic [7:0] mm_val, ss_val, mm_nxt, ss_nxt;
    logic       ss_carry, mm_carry;
    logic       hh_ok, set_ok, load_req, load_acc, count, day_end;

    // Load validation and handshake
    always_comb begin
        if (HOUR_MODE_12) begin
            hh_ok = bcd_le(set_hh, BcdMax12) && (set_hh != 8'h00);
        end else begin
            hh_ok = bcd_le(set_hh, BcdMax23);
        end
        set_ok = hh_ok && bcd_le(set_mm, BcdMax59) && bcd_le(set_ss, BcdMax59);
    end

    assign load_req = (state_q == StReady) && set_valid;
    assign load_acc = load_req && set_ok;
    // An accepted load discards the count tick of the same edge
    assign count    = run && !load_acc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReady: if (load_acc) state_d = StAck;
            StAck:   state_d = StReady;
            default: state_d = StReady;
        endcase
    end

    bcd_digit_pair #(
        .MAX_TENS  (4'd5),
        .MAX_UNITS (4'd9)
    ) u_sec (
        .clk_i      (clk_1hz),
        .reset_i    (reset),
        .inc_i      (count),
        .load_i     (load_acc),
        .load_val_i (set_ss),
        .val_o      (ss_val),
        .nxt_o      (ss_nxt),
        .carry_o    (ss_carry)
    );

    bcd_digit_pair #(
        .MAX_TENS  (4'd5),
        .MAX_UNITS (4'd9)
    ) u_min (
        .clk_i      (clk_1hz),
        .reset_i    (reset),
        .inc_i      (ss_carry),
        .load_i     (load_acc),
        .load_val_i (set_mm),
        .val_o      (mm_val),
        .nxt_o      (mm_nxt),
        .carry_o    (mm_carry)
    );

    // Hours: mode-dependent wrap; pm flips on 11 -> 12
    always_comb begin
        hh_d    = hh_q;
        pm_d    = pm_q;
        day_end = 1'b0;
        if (load_acc) begin
            hh_d = set_hh;
            pm_d = HOUR_MODE_12 ? set_pm : 1'b0;
        end else if (mm_carry) begin
            if (HOUR_MODE_12) begin
                if (hh_q == BcdMax12) begin
                    hh_d = 8'h01;
                end else if (hh_q == 8'h11) begin
                    hh_d    = BcdMax12;
                    pm_d    = !pm_q;
                    day_end = pm_q;
                end else begin
                    hh_d = bcd_inc(hh_q);
                end
            end else begin
                if (hh_q == BcdMax23) begin
                    hh_d    = 8'h00;
                    day_end = 1'b1;
                end else begin
                    hh_d = bcd_inc(hh_q);
                end
            end
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (reset) begin
            state_q     <= StReady;
            hh_q        <= HhReset;
            pm_q        <= 1'b0;
            tick_min_q  <= 1'b0;
            tick_hour_q <= 1'b0;
            tick_day_q  <= 1'b0;
            set_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            pm_q        <= pm_d;
            tick_min_q  <= ss_carry;
            tick_hour_q <= mm_carry;
            tick_day_q  <= day_end;
            set_error_q <= load_req && !set_ok;
        end
    end

    assign set_ready = (state_q == StReady);
    assign set_error = set_error_q;
    assign hh_bcd    = hh_q;
    assign mm_bcd    = mm_val;
    assign ss_bcd    = ss_val;
    assign pm        = pm_q;
    assign tick_min  = tick_min_q;
    assign tick_hour = tick_hour_q;
    assign tick_day  = tick_day_q;

    // Display decode; blanking happens before the polarity inversion
    logic [6:0]  hh_t_seg;
    logic [41:0] seg_raw;

    always_comb begin
        hh_t_seg = seg_decode(hh_q[7:4]);
        if (BLANK_LEAD_HOUR && (hh_q[7:4] == 4'd0)) begin
            hh_t_seg = SegOff;
        end
        seg_raw = {hh_t_seg, seg_decode(hh_q[3:0]),
                   seg_decode(mm_val[7:4]), seg_decode(mm_val[3:0]),
                   seg_decode(ss_val[7:4]), seg_decode(ss_val[3:0])};
        seg_out = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

`ifdef BCD_CLOCK_ALARM_EN
    logic alarm_q, alarm_d, alarm_hit;

    // Compare against the time being registered this edge, only when it changes
    always_comb begin
        alarm_hit = alarm_arm && (load_acc || count) &&
                    (hh_d == alarm_hh) && (mm_nxt == alarm_mm) && (ss_nxt == 8'h00) &&
                    (!HOUR_MODE_12 || (pm_d == alarm_pm));
        alarm_d = alarm_q;
        if (alarm_ack || !alarm_arm) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_out = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_hh, alarm_mm, alarm_pm, alarm_arm, alarm_ack, mm_nxt, ss_nxt};
    assign alarm_out    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_param.sv
// Directed, table-driven bench for bcd_clock_param. Instance A is 24-hour with
// plain segment polarity; instance B is 12-hour, active-low, lead-hour blanking.
module tb_bcd_clock_param;

`ifdef BCD_CLOCK_ALARM_EN
    localparam bit AlEn = 1'b1;
`else
    localparam bit AlEn = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       sv;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic [7:0] ehh;
        logic [7:0] emm;
        logic [7:0] ess;
        logic       epm;
        logic       erdy;
        logic       eerr;
        logic [2:0] etick;  // {day, hour, min}
        logic       eal;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_reset, a_run, a_sv, a_spm, a_rdy, a_err, a_pm;
    logic [7:0]  a_shh, a_smm, a_sss, a_hh, a_mm, a_ss;
    logic        a_tmin, a_thour, a_tday, a_al;
    logic [41:0] a_seg;
    logic [7:0]  a_alhh, a_almm;
    logic        a_alpm, a_alarm_arm, a_alack;

    // Instance B signals
    logic        b_reset, b_run, b_sv, b_spm, b_rdy, b_err, b_pm;
    logic [7:0]  b_shh, b_smm, b_sss, b_hh, b_mm, b_ss;
    logic        b_tmin, b_thour, b_tday, b_al;
    logic [41:0] b_seg;

    bcd_clock_param #(
        .HOUR_MODE_12    (1'b0),
        .SEG_ACTIVE_LOW  (1'b0),
        .BLANK_LEAD_HOUR (1'b0)
    ) u_dut_a (
        .clk_1hz   (clk),
        .reset     (a_reset),
        .run       (a_run),
        .set_valid (a_sv),
        .set_ready (a_rdy),
        .set_hh    (a_shh),
        .set_mm    (a_smm),
        .set_ss    (a_sss),
        .set_pm    (a_spm),
        .set_error (a_err),
        .hh_bcd    (a_hh),
        .mm_bcd    (a_mm),
        .ss_bcd    (a_ss),
        .pm        (a_pm),
        .tick_min  (a_tmin),
        .tick_hour (a_thour),
        .tick_day  (a_tday),
        .seg_out   (a_seg),
        .alarm_hh  (a_alhh),
        .alarm_mm  (a_almm),
        .alarm_pm  (a_alpm),
        .alarm_arm (a_alarm_arm),
        .alarm_ack (a_alack),
        .alarm_out (a_al)
    );

    bcd_clock_param #(
        .HOUR_MODE_12    (1'b1),
        .SEG_ACTIVE_LOW  (1'b1),
        .BLANK_LEAD_HOUR (1'b1)
    ) u_dut_b (
        .clk_1hz   (clk),
        .reset     (b_reset),
        .run       (b_run),
        .set_valid (b_sv),
        .set_ready (b_rdy),
        .set_hh    (b_shh),
        .set_mm    (b_smm),
        .set_ss    (b_sss),
        .set_pm    (b_spm),
        .set_error (b_err),
        .hh_bcd    (b_hh),
        .mm_bcd    (b_mm),
        .ss_bcd    (b_ss),
        .pm        (b_pm),
        .tick_min  (b_tmin),
        .tick_hour (b_thour),
        .tick_day  (b_tday),
        .seg_out   (b_seg),
        .alarm_hh  (8'h00),
        .alarm_mm  (8'h00),
        .alarm_pm  (1'b0),
        .alarm_arm (1'b0),
        .alarm_ack (1'b0),
        .alarm_out (b_al)
    );

    function automatic vec_t mk(input logic rst, input logic run, input logic sv,
                                input logic [7:0] hh, input logic [7:0] mm,
                                input logic [7:0] ss, input logic pm,
                                input logic [7:0] ehh, input logic [7:0] emm,
                                input logic [7:0] ess, input logic epm,
                                input logic erdy, input logic eerr,
                                input logic [2:0] etick, input logic eal);
        vec_t v;
        v.rst = rst;   v.run = run;   v.sv = sv;
        v.hh = hh;     v.mm = mm;     v.ss = ss;    v.pm = pm;
        v.ehh = ehh;   v.emm = emm;   v.ess = ess;  v.epm = epm;
        v.erdy = erdy; v.eerr = eerr; v.etick = etick; v.eal = eal;
        return v;
    endfunction

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [41:0] exp_seg(input logic [7:0] hh, input logic [7:0] mm,
                                            input logic [7:0] ss, input bit inv,
                                            input bit blank);
        logic [6:0]  ht;
        logic [41:0] s;
        ht = (blank && hh[7:4] == 4'd0) ? 7'b0000000 : pat(hh[7:4]);
        s  = {ht, pat(hh[3:0]), pat(mm[7:4]), pat(mm[3:0]), pat(ss[7:4]), pat(ss[3:0])};
        return inv ? ~s : s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_a(input vec_t v, input string tag);
        a_reset = v.rst; a_run = v.run; a_sv = v.sv;
        a_shh = v.hh; a_smm = v.mm; a_sss = v.ss; a_spm = v.pm;
        @(posedge clk);
        #1;
        check({tag, " hh"},    64'(a_hh), 64'(v.ehh));
        check({tag, " mm"},    64'(a_mm), 64'(v.emm));
        check({tag, " ss"},    64'(a_ss), 64'(v.ess));
        check({tag, " pm"},    64'(a_pm), 64'(v.epm));
        check({tag, " ready"}, 64'(a_rdy), 64'(v.erdy));
        check({tag, " error"}, 64'(a_err), 64'(v.eerr));
        check({tag, " ticks"}, 64'({a_tday, a_thour, a_tmin}), 64'(v.etick));
        check({tag, " seg"},   64'(a_seg), 64'(exp_seg(v.ehh, v.emm, v.ess, 1'b0, 1'b0)));
        check({tag, " alarm"}, 64'(a_al), 64'(v.eal));
    endtask

    task automatic apply_b(input vec_t v, input string tag);
        b_reset = v.rst; b_run = v.run; b_sv = v.sv;
        b_shh = v.hh; b_smm = v.mm; b_sss = v.ss; b_spm = v.pm;
        @(posedge clk);
        #1;
        check({tag, " hh"},    64'(b_hh), 64'(v.ehh));
        check({tag, " mm"},    64'(b_mm), 64'(v.emm));
        check({tag, " ss"},    64'(b_ss), 64'(v.ess));
        check({tag, " pm"},    64'(b_pm), 64'(v.epm));
        check({tag, " ready"}, 64'(b_rdy), 64'(v.erdy));
        check({tag, " error"}, 64'(b_err), 64'(v.eerr));
        check({tag, " ticks"}, 64'({b_tday, b_thour, b_tmin}), 64'(v.etick));
        check({tag, " seg"},   64'(b_seg), 64'(exp_seg(v.ehh, v.emm, v.ess, 1'b1, 1'b1)));
        check({tag, " alarm"}, 64'(b_al), 64'(v.eal));
    endtask

    vec_t ta[24];
    vec_t tb[12];

    initial begin
        // 24-hour table: rst run sv | hh mm ss pm | ehh emm ess epm rdy err tick al
        ta[0]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 3'b000, 0);
        ta[1]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0, 3'b000, 0);
        ta[2]  = mk(0, 1, 1, 8'h23, 8'h59, 8'h58, 0, 8'h23, 8'h59, 8'h58, 0, 0, 0, 3'b000, 0);
        ta[3]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h23, 8'h59, 8'h59, 0, 1, 0, 3'b000, 0);
        ta[4]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 3'b111, 0);
        ta[5]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0, 3'b000, 0);
        ta[6]  = mk(0, 1, 1, 8'h25, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h02, 0, 1, 1, 3'b000, 0);
        ta[7]  = mk(0, 1, 1, 8'h1A, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h03, 0, 1, 1, 3'b000, 0);
        ta[8]  = mk(0, 1, 1, 8'h12, 8'h60, 8'h00, 0, 8'h00, 8'h00, 8'h04, 0, 1, 1, 3'b000, 0);
        ta[9]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h05, 0, 1, 0, 3'b000, 0);
        ta[10] = mk(0, 1, 1, 8'h10, 8'h00, 8'h04, 0, 8'h10, 8'h00, 8'h04, 0, 0, 0, 3'b000, 0);
        ta[11] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h05, 0, 1, 0, 3'b000, 0);
        ta[12] = mk(0, 1, 1, 8'h08, 8'h30, 8'h00, 0, 8'h08, 8'h30, 8'h00, 0, 0, 0, 3'b000, 0);
        ta[13] = mk(0, 1, 1, 8'h08, 8'h30, 8'h00, 0, 8'h08, 8'h30, 8'h01, 0, 1, 0, 3'b000, 0);
        ta[14] = mk(0, 1, 1, 8'h08, 8'h30, 8'h00, 0, 8'h08, 8'h30, 8'h00, 0, 0, 0, 3'b000, 0);
        ta[15] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h08, 8'h30, 8'h00, 0, 1, 0, 3'b000, 0);
        ta[16] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h08, 8'h30, 8'h00, 0, 1, 0, 3'b000, 0);
        ta[17] = mk(0, 0, 1, 8'h09, 8'h59, 8'h59, 0, 8'h09, 8'h59, 8'h59, 0, 0, 0, 3'b000, 0);
        ta[18] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h00, 0, 1, 0, 3'b011, 0);
        ta[19] = mk(0, 1, 1, 8'h14, 8'h27, 8'h32, 0, 8'h14, 8'h27, 8'h32, 0, 0, 0, 3'b000, 0);
        ta[20] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h14, 8'h27, 8'h33, 0, 1, 0, 3'b000, 0);
        ta[21] = mk(1, 1, 1, 8'h05, 8'h05, 8'h05, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 3'b000, 0);
        ta[22] = mk(0, 1, 1, 8'h14, 8'h27, 8'h59, 0, 8'h14, 8'h27, 8'h59, 0, 0, 0, 3'b000, 0);
        ta[23] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h14, 8'h28, 8'h00, 0, 1, 0, 3'b001, 0);

        // 12-hour table
        tb[0]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 0, 1, 0, 3'b000, 0);
        tb[1]  = mk(0, 1, 1, 8'h11, 8'h59, 8'h59, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0, 3'b000, 0);
        tb[2]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 1, 1, 0, 3'b011, 0);
        tb[3]  = mk(0, 1, 1, 8'h12, 8'h59, 8'h59, 1, 8'h12, 8'h59, 8'h59, 1, 0, 0, 3'b000, 0);
        tb[4]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 1, 0, 3'b011, 0);
        tb[5]  = mk(0, 1, 1, 8'h11, 8'h59, 8'h59, 1, 8'h11, 8'h59, 8'h59, 1, 0, 0, 3'b000, 0);
        tb[6]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 0, 1, 0, 3'b111, 0);
        tb[7]  = mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h01, 0, 1, 1, 3'b000, 0);
        tb[8]  = mk(0, 1, 1, 8'h13, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h02, 0, 1, 1, 3'b000, 0);
        tb[9]  = mk(0, 1, 1, 8'h09, 8'h59, 8'h59, 0, 8'h09, 8'h59, 8'h59, 0, 0, 0, 3'b000, 0);
        tb[10] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h00, 0, 1, 0, 3'b011, 0);
        tb[11] = mk(0, 0, 1, 8'h12, 8'h00, 8'h00, 1, 8'h12, 8'h00, 8'h00, 1, 0, 0, 3'b000, 0);

        a_alhh = 8'h07; a_almm = 8'h15; a_alpm = 1'b0; a_alarm_arm = 1'b0; a_alack = 1'b0;
        b_reset = 1'b1; b_run = 1'b0; b_sv = 1'b0;
        b_shh = 8'h00; b_smm = 8'h00; b_sss = 8'h00; b_spm = 1'b0;

        for (int i = 0; i < 24; i++) begin
            apply_a(ta[i], $sformatf("A[%0d]", i));
        end

        // Alarm sequence at 07:15 on instance A
        a_alarm_arm = 1'b1;
        apply_a(mk(0, 1, 1, 8'h07, 8'h14, 8'h58, 0, 8'h07, 8'h14, 8'h58, 0, 0, 0, 3'b000, 0),
                "AL load");
        apply_a(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h07, 8'h14, 8'h59, 0, 1, 0, 3'b000, 0),
                "AL 14:59");
        apply_a(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h07, 8'h15, 8'h00, 0, 1, 0, 3'b001, AlEn),
                "AL hit");
        apply_a(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h07, 8'h15, 8'h01, 0, 1, 0, 3'b000, AlEn),
                "AL sticky");
        a_alack = 1'b1;
        apply_a(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h07, 8'h15, 8'h02, 0, 1, 0, 3'b000, 0),
                "AL ack");
        a_alack = 1'b0;
        apply_a(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h07, 8'h15, 8'h03, 0, 1, 0, 3'b000, 0),
                "AL after");
        a_alarm_arm = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_b(tb[i], $sformatf("B[%0d]", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_clock_param.md
Name: bcd_clock_param

Overview:
- Parametrised successor to the team's fixed 24-hour digital clock.
- BCD HH:MM:SS timekeeper advancing once per clk_1hz edge when run=1.
- Adds:
  - 12/24-hour mode
  - validated time-load handshake
  - rollover strobes
  - selectable segment polarity and leading-zero blanking
- Drives the six-digit 7-segment display bank, with an optional alarm comparator.

Parameters:
- HOUR_MODE_12, 0, 0 = 24-hour (00..23); 1 = 12-hour (12,01..11 with pm flag)
- SEG_ACTIVE_LOW, 0, 1 = invert all segment outputs (common-anode panels)
- BLANK_LEAD_HOUR, 0, 1 = hour-tens digit shows all segments off when its value is 0

Ports:
- clk_1hz  in  1  counting clock; one rising edge = one second
- reset  in  1  synchronous, active-high; sampled on clk_1hz
- run  in  1  1 = advance time each edge; 0 = hold
- set_valid  in  1  load request
- set_ready  out  1  block can accept a load this cycle
- set_hh  in  8  BCD hours to load
- set_mm  in  8  BCD minutes to load
- set_ss  in  8  BCD seconds to load
- set_pm  in  1  pm flag to load; ignored in 24-hour mode
- set_error  out  1  one-cycle pulse: rejected load
- hh_bcd  out  8  current hours, BCD
- mm_bcd  out  8  current minutes, BCD
- ss_bcd  out  8  current seconds, BCD
- pm  out  1  pm flag; constant 0 in 24-hour mode
- tick_min  out  1  one-cycle pulse on minute rollover
- tick_hour  out  1  one-cycle pulse on hour rollover
- tick_day  out  1  one-cycle pulse on day rollover (23:59:59->00:00:00, or 11:59:59 pm->12:00:00 am)
- seg_out  out  42  six digits x 7 segments {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}, each abcdefg MSB=a
- alarm_hh  in  8  BCD alarm hours
- alarm_mm  in  8  BCD alarm minutes
- alarm_pm  in  1  alarm pm flag
- alarm_arm  in  1  alarm armed
- alarm_ack  in  1  clears alarm
- alarm_out  out  1  sticky alarm flag

Behaviour:
- Reset (synchronous):
  - time = 00:00:00 (24-hour) or 12:00:00, pm=0 (12-hour)
  - set_ready=1; set_error, tick_* and alarm_out = 0
  - Reset overrides load and count in the same edge.
- Counting, each edge with run=1 and no accepted load:
  - ss_u 0..9; ss_t 0..5; mm_u 0..9; mm_t 0..5, each carrying to the next digit.
  - 24-hour hours: 00..23, then 00.
  - 12-hour hours: 12->01, 09->10, 11->12. pm toggles on the 11:59:59->12:00:00 transition.
  - All carries are resolved in one edge; e.g. 23:59:59 -> 00:00:00 in a single cycle.
- Tick strobes:
  - Asserted on the same edge the rolled-over value is registered; held for exactly one cycle.
  - tick_day implies tick_hour, which implies tick_min.
- Load FSM, states READY and ACK:
  - READY: set_ready=1. When set_valid=1, inputs are validated:
    - every nibble must be <=9
    - ss,mm <= 0x59
    - hh <= 0x23 (24-hour), or 0x01..0x12 (12-hour)
  - Valid load: time <= set values on that edge; the count tick in the same edge is discarded (load wins). Go to ACK.
  - Invalid load: time unchanged; counting proceeds normally; set_error pulses one cycle; stay in READY.
  - ACK: set_ready=0 for one cycle; counting resumes. Return to READY unconditionally.
  - A set_valid held high therefore reloads every second cycle.
- Outputs:
  - BCD outputs and pm are registered.
  - seg_out is a combinational decode of the registered digits: zero cycles of lag; display matches the BCD outputs on every cycle.
  - Digit map: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; others = all off.
  - Blanking is applied before polarity inversion.
- run=0: time frozen, no ticks; loads are still accepted.

Optional Feature:
- Macro: BCD_CLOCK_ALARM_EN.
- When defined:
  - alarm_out sets on the edge where the new time equals alarm_hh:alarm_mm:00, with pm also matching in 12-hour mode, and alarm_arm=1.
  - The match source can be counting or a load.
  - alarm_out stays high until alarm_ack=1 (clears next edge; ack wins over a simultaneous set) or alarm_arm=0.
- When undefined: the alarm ports remain, inputs are ignored, alarm_out is tied to 0.

Decomposition:
- Package bcd_clock_pkg:
  - seven-segment digit constants and decode function
  - BCD limit constants (59, 23, 12)
  - load FSM state enum
- One sub-module, bcd_digit_pair:
  - two-digit BCD counter with parameter MAX_TENS/MAX_UNITS, inc-in and carry-out
  - instantiated for seconds and minutes
  - hours stay in the top level because of mode-dependent wrap

Test Plan:
- 24-hour mode: load 23:59:58, run 2 edges -> 23:59:59 then 00:00:00; tick_min, tick_hour and tick_day all pulse on the second edge.
- 12-hour mode: load 11:59:59 pm=0, 1 edge -> 12:00:00 pm=1; from 12:59:59 -> 01:00:00, pm unchanged.
- Load 0x25:00:00 in 24-hour mode, or 0x1A:xx:xx -> set_error pulses, time unchanged, set_ready stays 1.
- set_valid coincident with a count tick from 10:00:05 loading 08:30:00 -> next value 08:30:00, set_ready=0 one cycle, next edge 08:30:01.
- Reset asserted mid-count at 14:27:33 -> next edge time = reset value, seg_out = digit-0 patterns (hour-tens all off if BLANK_LEAD_HOUR=1; inverted if SEG_ACTIVE_LOW=1).
- BCD_CLOCK_ALARM_EN: alarm 07:15, armed; count through 07:14:59->07:15:00 -> alarm_out=1 until alarm_ack; without the macro -> alarm_out stays 0.
